// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory responder: access sizes,
// FSM states, lane alignment and byte-enable generation.
// Optional build macro honoured by users of this package: MISALIGN_TRAP_EN.
package mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmr_state_t;

  // Raw size encoding 2'b11 is treated as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  // Forces the low address bits onto the natural boundary of the access.
  function automatic logic [1:0] align_lo(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return addr_lo;
      SZ_HALF: return {addr_lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

  function automatic logic [WORD_BYTES-1:0] byte_en(input mem_size_t size, input logic [1:0] addr_lo);
    logic [1:0]            lo;
    logic [WORD_BYTES-1:0] be;
    lo = align_lo(size, addr_lo);
    case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_byte_align.sv
// Combinational lane steering: replicates store data with byte enables and
// extracts/extends load lanes from a RAM word. No state, zero latency.
// Unaligned offsets are snapped to the access boundary here.
module lsu_byte_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_rdata
);

  mem_size_t   w_size;
  logic [1:0]  w_lo;
  logic [31:0] w_shifted;

  assign w_size    = mem_size_t'(i_size);
  assign w_lo      = align_lo(w_size, i_addr_lo);
  assign w_shifted = i_rword >> {w_lo, 3'b000};
  assign o_be      = byte_en(w_size, i_addr_lo);

  // Store path: replicate the LSB-aligned data across every lane it may land in.
  always_comb begin
    o_wdata = i_wdata;
    case (w_size)
      SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
      SZ_HALF: o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

  // Load path: pick the addressed lane(s) and sign- or zero-extend.
  always_comb begin
    o_rdata = w_shifted;
    case (w_size)
      SZ_BYTE: o_rdata = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_rdata = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: o_rdata = w_shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder over an internal word RAM; build macro MISALIGN_TRAP_EN.
// Latency: accept at edge T, rsp_valid high in the cycle after edge T+LATENCY.
// Backpressure: stall held from request presentation through BUSY; one request in flight.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        req_ready,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  dmr_state_t    r_state;
  dmr_state_t    w_next;
  logic          w_accept;
  logic          w_commit;

  logic [3:0]    r_cnt;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [31:0]   r_rdata;

  logic [31:0]   r_mem [DEPTH];

  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [31:0]   w_wrep;
  logic [3:0]    w_be;
  logic [31:0]   w_load;
  logic          w_mis;
  logic          w_unused_addr;

  // Address bits above the RAM index are deliberately dropped (wrap modulo DEPTH).
  assign w_unused_addr = ^req_addr[31:AW+2];

  assign w_idx   = r_addr[AW+1:2];
  assign w_rword = r_mem[w_idx];

`ifdef MISALIGN_TRAP_EN
  logic r_err;
  assign w_mis   = misaligned(mem_size_t'(r_size), r_addr[1:0]);
  assign rsp_err = r_err;
`else
  assign w_mis   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  lsu_byte_align u_align (
    .i_size     (r_size),
    .i_addr_lo  (r_addr[1:0]),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .i_rword    (w_rword),
    .o_wdata    (w_wrep),
    .o_be       (w_be),
    .o_rdata    (w_load)
  );

  // State register; async reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_commit  = 1'b0;
    req_ready = 1'b0;
    stall     = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (r_cnt == 4'd0) begin
          w_commit = 1'b1;
          w_next   = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;

  // Request latches, latency counter and registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_rdata <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      r_err   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_INIT;
        r_addr  <= req_addr[AW+1:0];
        r_wdata <= req_wdata;
        r_we    <= req_we;
        r_size  <= decode_size(req_size);
        r_uns   <= req_unsigned;
      end else if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_rdata <= (r_we || w_mis) ? 32'd0 : w_load;
`ifdef MISALIGN_TRAP_EN
        r_err   <= w_mis;
`endif
      end
    end
  end

  // RAM write on commit; trapped misaligned stores never touch the array.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_mis) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (DEPTH=1024, LATENCY=2).
// Vector table plus hand sequences for reset/RESP corner cases and a random
// sweep against a small memory model; responses checked via a scoreboard queue.
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_ready    (req_ready),
    .stall        (stall),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  rsp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid with empty scoreboard at %0t", $time);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  // One pipeline-style request: valid held while stalled, dropped on the RESP cycle
  // (or one cycle later when hold is set, to probe re-acceptance).
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit hold);
    int  lat;
    int  scnt;
    bit  got;
    rsp_t e;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    #1;
    scnt = stall ? 1 : 0;
    lat  = 0;
    got  = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) got = 1'b1;
      else if (stall) scnt++;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: no rsp_valid within 40 cycles for addr 0x%08h", addr);
    end
    check("latency_cycles", lat, LAT + 1);
    check("stall_cycles", scnt, LAT + 1);
    check("resp_ready_low", {31'd0, req_ready}, 32'd0);
    if (hold) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("no_reaccept_ready", {31'd0, req_ready}, 32'd1);
    end else begin
      req_valid = 1'b0;
    end
  endtask

  // Reference model for the random sweep: 16 words at byte address 0x100.
  logic [31:0] mdl [16];

  function automatic logic [31:0] model_load(input logic [31:0] w, input int sz,
                                             input logic [1:0] lo, input logic uns);
    logic [31:0] s;
    s = w >> (8 * lo);
    if (sz == 0) return uns ? {24'd0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
    if (sz == 1) return uns ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    return w;
  endfunction

  vec_t vecs[$];

  initial begin
    req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_ready", {31'd0, req_ready}, 32'd1);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    //                 we    addr          wdata         sz   uns   exp            err
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'h80F1_7F01, 2'd2, 1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0023, 32'h0,         2'd0, 1'b0, 32'hFFFF_FF80, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0023, 32'h0,         2'd0, 1'b1, 32'h0000_0080, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0022, 32'h0,         2'd1, 1'b0, 32'hFFFF_80F1, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         2'd1, 1'b1, 32'h0000_7F01, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         2'd0, 1'b0, 32'h0000_0001, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0030, 32'h1122_3344, 2'd2, 1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0031, 32'h0000_00AA, 2'd0, 1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0030, 32'h0,         2'd2, 1'b0, 32'h1122_AA44, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0032, 32'h1234_BEEF, 2'd1, 1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0030, 32'h0,         2'd2, 1'b0, 32'hBEEF_AA44, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_1000, 32'h0000_0005, 2'd2, 1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         2'd2, 1'b0, 32'h0000_0005, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         2'd3, 1'b0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0040, 32'h1234_5678, 2'd2, 1'b0, 32'h0000_0000, 1'b0});

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns,
             vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
    end

    // Valid still high through RESP must not start a second access.
    do_req(1'b0, 32'h0000_0010, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("idle_after_hold_ready", {31'd0, req_ready}, 32'd1);

    // Reset while a store to 0x40 is in BUSY: no response, no RAM write.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40;
    req_wdata = 32'hCAFE_F00D; req_size = 2'd2; req_unsigned = 1'b0;
    @(negedge clk);
    check("busy_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    check("rst_busy_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy_stall", {31'd0, stall}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_busy_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    reset = 1'b0;
    do_req(1'b0, 32'h0000_0040, 32'h0, 2'd2, 1'b0, 32'h1234_5678, 1'b0, 1'b0);

    // Reset in the RESP cycle drops rsp_valid at once.
    begin
      rsp_t e;
      bit   got;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2;
      e.rdata = 32'hDEAD_BEEF; e.err = 1'b0;
      sb_q.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (rsp_valid) got = 1'b1;
      end
      check("resp_seen_before_reset", {31'd0, got}, 32'd1);
      #1;
      reset = 1'b1;
      req_valid = 1'b0;
      #1;
      check("rst_resp_drop", {31'd0, rsp_valid}, 32'd0);
      check("rst_resp_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
    end

`ifdef MISALIGN_TRAP_EN
    do_req(1'b0, 32'h0000_0042, 32'h0,         2'd2, 1'b0, 32'h0, 1'b1, 1'b0);
    do_req(1'b1, 32'h0000_0042, 32'h9999_9999, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0);
    do_req(1'b0, 32'h0000_0041, 32'h0,         2'd1, 1'b0, 32'h0, 1'b1, 1'b0);
    do_req(1'b0, 32'h0000_0040, 32'h0,         2'd2, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
`else
    do_req(1'b0, 32'h0000_0042, 32'h0,         2'd2, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
    do_req(1'b0, 32'h0000_0041, 32'h0,         2'd1, 1'b0, 32'h0000_5678, 1'b0, 1'b0);
    do_req(1'b1, 32'h0000_0042, 32'h9999_9999, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 32'h0000_0040, 32'h0,         2'd2, 1'b0, 32'h9999_9999, 1'b0, 1'b0);
`endif

    // Random aligned traffic over a 16-word window against the model.
    for (int i = 0; i < 16; i++) begin
      mdl[i] = $urandom;
      do_req(1'b1, 32'h100 + 32'(4 * i), mdl[i], 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    for (int n = 0; n < 24; n++) begin
      int          wi;
      int          sz;
      logic [1:0]  lo;
      logic        we;
      logic        uns;
      logic [31:0] wd;
      wi  = $urandom_range(15);
      sz  = $urandom_range(2);
      we  = 1'($urandom_range(1));
      uns = 1'($urandom_range(1));
      wd  = $urandom;
      lo  = 2'($urandom_range(3));
      if (sz == 1) lo[0] = 1'b0;
      if (sz == 2) lo = 2'b00;
      if (we) begin
        if (sz == 0)      mdl[wi][8*lo +: 8]  = wd[7:0];
        else if (sz == 1) mdl[wi][8*lo +: 16] = wd[15:0];
        else              mdl[wi] = wd;
        do_req(1'b1, 32'h100 + 32'(4 * wi) + 32'(lo), wd, 2'(sz), uns, 32'h0, 1'b0, 1'b0);
      end else begin
        do_req(1'b0, 32'h100 + 32'(4 * wi) + 32'(lo), wd, 2'(sz), uns,
               model_load(mdl[wi], sz, lo, uns), 1'b0, 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
